// File: rtl/frame_diff_bin.sv
// Frame-difference motion detector: binarises |cur - prev| against a threshold with a
// 2-cycle pipeline and reports the motion bounding box and pixel count of each frame.
module frame_diff_bin #(
    parameter logic [10:0] IMG_HDISP   = 11'd640,
    parameter logic [10:0] IMG_VDISP   = 11'd480,
    parameter logic [7:0]  DIFF_THRESH = 8'd20
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [7:0]  cur_gray,
    input  logic [7:0]  prev_gray,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] bin_data,
    output logic [10:0] box_x_min,
    output logic [10:0] box_x_max,
    output logic [10:0] box_y_min,
    output logic [10:0] box_y_max,
    output logic [19:0] motion_cnt,
    output logic        motion_flag,
    output logic        box_valid
);

    localparam logic [10:0] X_LAST  = IMG_HDISP - 11'd1;
    localparam logic [10:0] Y_LAST  = IMG_VDISP - 11'd1;
    localparam logic [19:0] CNT_MAX = 20'hFFFFF;

    typedef struct packed {
        logic [10:0] x_min;
        logic [10:0] x_max;
        logic [10:0] y_min;
        logic [10:0] y_max;
        logic [19:0] cnt;
    } stats_t;

    localparam stats_t STATS_INIT = '{x_min: 11'h7FF, x_max: 11'h000,
                                      y_min: 11'h7FF, y_max: 11'h000,
                                      cnt: 20'h00000};

    // ---------------- Stage 1: absolute difference ----------------
    logic [7:0] diff_d, diff_q;
    logic       vs1_q, hr1_q, ck1_q;

    always_comb begin
        diff_d = (cur_gray >= prev_gray) ? (cur_gray - prev_gray) : (prev_gray - cur_gray);
    end

    // ---------------- Stage 2: threshold ----------------
    logic bin_d, bin_q;
    logic vs2_q, hr2_q, ck2_q;

    // Gating with the delayed qualifiers keeps bin_data at 0 outside active pixels.
    always_comb begin
        bin_d = hr1_q & ck1_q & (diff_q > DIFF_THRESH);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            diff_q <= '0;
            vs1_q  <= 1'b0;
            hr1_q  <= 1'b0;
            ck1_q  <= 1'b0;
            bin_q  <= 1'b0;
            vs2_q  <= 1'b0;
            hr2_q  <= 1'b0;
            ck2_q  <= 1'b0;
        end else begin
            diff_q <= diff_d;
            vs1_q  <= per_frame_vsync;
            hr1_q  <= per_frame_href;
            ck1_q  <= per_frame_clken;
            bin_q  <= bin_d;
            vs2_q  <= vs1_q;
            hr2_q  <= hr1_q;
            ck2_q  <= ck1_q;
        end
    end

    assign post_frame_vsync = vs2_q;
    assign post_frame_href  = hr2_q;
    assign post_frame_clken = ck2_q;
    assign bin_data         = {24{bin_q}};

    // ---------------- Position tracking on stage-2 outputs ----------------
    logic        vs3_q, hr3_q;
    logic        pix_v, line_end, frame_end, motion_px;
    logic [10:0] x_cnt_d, x_cnt_q;
    logic [10:0] y_cnt_d, y_cnt_q;

    assign pix_v     = hr2_q & ck2_q;
    assign line_end  = hr3_q & ~hr2_q;
    assign frame_end = vs3_q & ~vs2_q;
    assign motion_px = bin_q & pix_v;

    // The pixel's coordinate is the count before it is incremented.
    always_comb begin
        x_cnt_d = x_cnt_q;
        if (line_end) begin
            x_cnt_d = '0;
        end else if (pix_v && (x_cnt_q != X_LAST)) begin
            x_cnt_d = x_cnt_q + 11'd1;
        end
    end

    always_comb begin
        y_cnt_d = y_cnt_q;
        if (!vs2_q) begin
            y_cnt_d = '0;
        end else if (line_end && (y_cnt_q != Y_LAST)) begin
            y_cnt_d = y_cnt_q + 11'd1;
        end
    end

    // ---------------- Running statistics and frame latch ----------------
    stats_t run_d, run_q;
    stats_t box_d, box_q;
    logic   flag_d, flag_q;
    logic   armed_d, armed_q;
    logic   box_valid_d, box_valid_q;

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        run_d = run_q;
        if (!vs2_q) begin
            run_d = STATS_INIT;
        end else if (motion_px) begin
            if (x_cnt_q < run_q.x_min) run_d.x_min = x_cnt_q;
            if (x_cnt_q > run_q.x_max) run_d.x_max = x_cnt_q;
            if (y_cnt_q < run_q.y_min) run_d.y_min = y_cnt_q;
            if (y_cnt_q > run_q.y_max) run_d.y_max = y_cnt_q;
            if (run_q.cnt != CNT_MAX)  run_d.cnt   = run_q.cnt + 20'd1;
        end
    end

    // A frame is only reported once its start (vsync low) was seen after reset.
    always_comb begin
        armed_d     = armed_q | ~vs2_q;
        box_d       = box_q;
        flag_d      = flag_q;
        box_valid_d = frame_end & armed_q;
        if (frame_end && armed_q) begin
            if (run_q.cnt == '0) begin
                box_d  = '0;
                flag_d = 1'b0;
            end else begin
                box_d  = run_q;
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs3_q       <= 1'b0;
            hr3_q       <= 1'b0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            run_q       <= STATS_INIT;
            box_q       <= '0;
            flag_q      <= 1'b0;
            armed_q     <= 1'b0;
            box_valid_q <= 1'b0;
        end else begin
            vs3_q       <= vs2_q;
            hr3_q       <= hr2_q;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            run_q       <= run_d;
            box_q       <= box_d;
            flag_q      <= flag_d;
            armed_q     <= armed_d;
            box_valid_q <= box_valid_d;
        end
    end

    assign box_x_min   = box_q.x_min;
    assign box_x_max   = box_q.x_max;
    assign box_y_min   = box_q.y_min;
    assign box_y_max   = box_q.y_max;
    assign motion_cnt  = box_q.cnt;
    assign motion_flag = flag_q;
    assign box_valid   = box_valid_q;

endmodule
